// File: rtl/backprop_update_buffer_if.sv
// rtl/backprop_update_buffer_if.sv - slice input and update-drain handshake bundle
interface backprop_update_buffer_if #(
  parameter int size      = 3,
  parameter int data_size = 16
);
  logic [data_size*size-1:0] diff_dense;
  logic [data_size*size-1:0] diff_start;
  logic [data_size*size-1:0] diff_cost;
  logic [data_size*size-1:0] diff_to_all;
  logic [31:0]               current_layer;
  logic [31:0]               current_row;
  logic                      is_last_layer;
  logic                      start_new_layer;
  logic                      read_update_data;
  logic                      active_train;
  logic                      update_ready;
  logic                      update_valid;
  logic [data_size*size-1:0] update_data;
  logic [31:0]               update_layer;
  logic [31:0]               update_row;
  logic                      update_done;
  logic                      busy;
  logic                      error;

  modport master (
    output diff_dense, diff_start, diff_cost, diff_to_all,
    output current_layer, current_row, is_last_layer, start_new_layer,
    output read_update_data, active_train, update_ready,
    input  update_valid, update_data, update_layer, update_row,
    input  update_done, busy, error
  );

  modport slave (
    input  diff_dense, diff_start, diff_cost, diff_to_all,
    input  current_layer, current_row, is_last_layer, start_new_layer,
    input  read_update_data, active_train, update_ready,
    output update_valid, update_data, update_layer, update_row,
    output update_done, busy, error
  );
endinterface

// File: rtl/backprop_update_buffer.sv
// rtl/backprop_update_buffer.sv - gradient-row pipeline, per-layer row buffer and update drain
module backprop_update_buffer #(
  parameter int size           = 3,
  parameter int data_size      = 16,
  parameter int frac_bits      = 8,
  parameter int max_layer_size = 4,
  parameter int lr_shift       = 2
) (
  input logic                     clk,
  input logic                     reset,
  backprop_update_buffer_if.slave bus
);
  localparam int vw = data_size * size;
  localparam int lw = (max_layer_size > 1) ? $clog2(max_layer_size) : 1;
  localparam int rw = (size > 1) ? $clog2(size) : 1;
  localparam logic [rw-1:0] last_row = rw'(size - 1);
  localparam logic signed [2*data_size-1:0] sat_max = (2 ** (data_size - 1)) - 1;
  localparam logic signed [2*data_size-1:0] sat_min = -(2 ** (data_size - 1));

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DRAIN} state_t;

  state_t            state, next_state;
  logic              flush_cnt;
  logic [lw-1:0]     max_layer, rd_layer;
  logic [rw-1:0]     rd_row;
  logic              error_r, done_r;

  logic              s1_valid, s2_valid;
  logic [vw-1:0]     s1_e, s2_g, dense_d1;
  logic [lw-1:0]     s1_layer, s2_layer;
  logic [rw-1:0]     s1_row, s2_row;
  logic [vw-1:0]     e_next, g_next;
  logic signed [data_size-1:0] g_lane;
  logic [vw-1:0]     grad_store [size][max_layer_size];

  logic cap_raw, first_slice, load, in_range, overrun, fire, last_hs;

  // Signed Q-format multiply: arithmetic shift back to the lane format, then saturate.
  function automatic logic [data_size-1:0] mul(input logic [data_size-1:0] a,
                                               input logic [data_size-1:0] b);
    logic signed [2*data_size-1:0] aw, bw, p;
    aw = {{data_size{a[data_size-1]}}, a};
    bw = {{data_size{b[data_size-1]}}, b};
    p  = (aw * bw) >>> frac_bits;
    if (p > sat_max)      mul = sat_max[data_size-1:0];
    else if (p < sat_min) mul = sat_min[data_size-1:0];
    else                  mul = p[data_size-1:0];
  endfunction

  assign cap_raw     = bus.active_train && !bus.read_update_data;
  assign first_slice = cap_raw && bus.start_new_layer && (bus.current_layer == 32'd0);
  assign load        = ((state == IDLE) && first_slice) || ((state == CAPTURE) && cap_raw);
  assign in_range    = (bus.current_layer < 32'(max_layer_size)) && (bus.current_row < 32'(size));
  assign overrun     = ((state == FLUSH) || (state == DRAIN)) && first_slice;
  assign fire        = (state == DRAIN) && bus.update_ready;
  assign last_hs     = fire && (rd_layer == max_layer) && (rd_row == last_row);

  // Per-lane arithmetic for both pipeline stages.
  always_comb begin
    e_next = '0;
    g_next = '0;
    g_lane = '0;
    for (int i = 0; i < size; i++) begin
      e_next[i*data_size +: data_size] =
        mul(bus.is_last_layer ? bus.diff_cost[i*data_size +: data_size]
                              : bus.diff_to_all[i*data_size +: data_size],
            bus.diff_start[i*data_size +: data_size]);
      g_lane = mul(s1_e[i*data_size +: data_size], dense_d1[i*data_size +: data_size]);
      g_next[i*data_size +: data_size] = g_lane >>> lr_shift;
    end
  end

  // Two-stage pipeline; out-of-range slices never become valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_e     <= '0;
      s2_g     <= '0;
      dense_d1 <= '0;
      s1_layer <= '0;
      s2_layer <= '0;
      s1_row   <= '0;
      s2_row   <= '0;
    end else begin
      s1_valid <= load && in_range;
      s1_e     <= e_next;
      s1_layer <= bus.current_layer[lw-1:0];
      s1_row   <= bus.current_row[rw-1:0];
      dense_d1 <= bus.diff_dense;
      s2_valid <= s1_valid;
      s2_g     <= g_next;
      s2_layer <= s1_layer;
      s2_row   <= s1_row;
    end
  end

  // Gradient row buffer, written as stage-2 results retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < size; r++)
        for (int l = 0; l < max_layer_size; l++)
          grad_store[r][l] <= '0;
    end else if (s2_valid) begin
      grad_store[s2_row][s2_layer] <= s2_g;
    end
  end

  // Next-state selection for capture / flush / drain sequencing.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (first_slice) next_state = CAPTURE;
      CAPTURE: if (bus.read_update_data) next_state = FLUSH;
      FLUSH:   if (flush_cnt) next_state = DRAIN;
      DRAIN:   if (last_hs) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register, read pointers, last-layer tracking and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
      max_layer <= '0;
      rd_layer  <= '0;
      rd_row    <= '0;
      error_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state     <= next_state;
      done_r    <= last_hs;
      flush_cnt <= (state == FLUSH) && !flush_cnt;
      if ((load && !in_range) || overrun)
        error_r <= 1'b1;
      if ((state == IDLE) && first_slice)
        max_layer <= '0;
      else if ((state == CAPTURE) && cap_raw && bus.is_last_layer && in_range)
        max_layer <= bus.current_layer[lw-1:0];
      if (state == FLUSH) begin
        rd_layer <= '0;
        rd_row   <= '0;
      end else if (fire) begin
        if (rd_row == last_row) begin
          rd_row   <= '0;
          rd_layer <= rd_layer + 1'b1;
        end else begin
          rd_row <= rd_row + 1'b1;
        end
      end
    end
  end

  assign bus.update_valid = (state == DRAIN);
  assign bus.update_data  = (state == DRAIN) ? grad_store[rd_row][rd_layer] : '0;
  assign bus.update_layer = (state == DRAIN) ? 32'(rd_layer) : 32'd0;
  assign bus.update_row   = (state == DRAIN) ? 32'(rd_row) : 32'd0;
  assign bus.update_done  = done_r;
  assign bus.busy         = (state != IDLE);
  assign bus.error        = error_r;
endmodule

// File: tb/tb_backprop_update_buffer.sv
// tb/tb_backprop_update_buffer.sv - directed self-checking bench for backprop_update_buffer
module tb_backprop_update_buffer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  backprop_update_buffer_if #(.size(3), .data_size(16)) bus();

  backprop_update_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_hs;
  int          n_done;
  int          hold_err;
  logic [47:0] got_data  [16];
  logic [31:0] got_layer [16];
  logic [31:0] got_row   [16];

  function automatic logic [47:0] rep(input logic [15:0] v);
    rep = {v, v, v};
  endfunction

  task automatic idle_inputs();
    bus.active_train     = 1'b0;
    bus.read_update_data = 1'b0;
    bus.start_new_layer  = 1'b0;
    bus.is_last_layer    = 1'b0;
    bus.update_ready     = 1'b0;
    bus.current_layer    = 32'd0;
    bus.current_row      = 32'd0;
  endtask

  task automatic send_slice(input int layer, input int row, input bit last, input bit start,
                            input logic [47:0] cost, input logic [47:0] to_all,
                            input logic [47:0] st, input logic [47:0] dense);
    bus.current_layer    = layer;
    bus.current_row      = row;
    bus.is_last_layer    = last;
    bus.start_new_layer  = start;
    bus.diff_cost        = cost;
    bus.diff_to_all      = to_all;
    bus.diff_start       = st;
    bus.diff_dense       = dense;
    bus.active_train     = 1'b1;
    bus.read_update_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic capture_one_layer(input logic [15:0] cost, input logic [15:0] st,
                                   input logic [15:0] dense);
    for (int r = 0; r < 3; r++)
      send_slice(0, r, 1'b1, r == 0, rep(cost), rep(16'h0000), rep(st), rep(dense));
  endtask

  task automatic capture_two_layers();
    for (int r = 0; r < 3; r++)
      send_slice(0, r, 1'b0, r == 0, rep(16'h0400), rep(16'hFF00), rep(16'h0100), rep(16'h0100));
    for (int r = 0; r < 3; r++)
      send_slice(1, r, 1'b1, r == 0, rep(16'h0200), rep(16'hFF00), rep(16'h0080), rep(16'h0300));
  endtask

  // Runs the update phase for a fixed window, recording each handshake.
  task automatic drain(input int budget, input bit bp, input bit inject);
    logic [3:0]  pat = 4'b1001;
    bit          pend;
    bit          injected;
    logic [47:0] pd;
    logic [31:0] pl, pr;
    n_hs = 0; n_done = 0; hold_err = 0; pend = 0; injected = 0;
    pd = '0; pl = '0; pr = '0;
    for (int i = 0; i < 16; i++) begin
      got_data[i] = 'x; got_layer[i] = 'x; got_row[i] = 'x;
    end
    bus.active_train    = 1'b1;
    bus.start_new_layer = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (bus.update_done === 1'b1) n_done++;
      if (pend && (bus.update_valid !== 1'b1 || bus.update_data !== pd ||
                   bus.update_layer !== pl || bus.update_row !== pr))
        hold_err++;
      bus.update_ready = bp ? pat[c % 4] : 1'b1;
      if (inject && !injected && bus.update_valid === 1'b1) begin
        bus.read_update_data = 1'b0;
        bus.start_new_layer  = 1'b1;
        bus.current_layer    = 32'd0;
        injected = 1;
      end else begin
        bus.read_update_data = 1'b1;
        bus.start_new_layer  = 1'b0;
      end
      if (bus.update_valid === 1'b1) begin
        if (bus.update_ready) begin
          if (n_hs < 16) begin
            got_data[n_hs] = bus.update_data;
            got_layer[n_hs] = bus.update_layer;
            got_row[n_hs] = bus.update_row;
          end
          n_hs++;
          pend = 0;
        end else begin
          pend = 1; pd = bus.update_data; pl = bus.update_layer; pr = bus.update_row;
        end
      end else begin
        pend = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.update_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.update_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    checks++; if (bus.update_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.update_done); end
    checks++; if (bus.update_data !== 48'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.update_data); end
  endtask

  task automatic test_single_layer();
    capture_one_layer(16'h0200, 16'h0080, 16'h0300);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    drain(20, 1'b0, 1'b0);
    checks++; if (n_hs !== 3) begin failures++; $display("FAIL single_count got=%0d exp=3", n_hs); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL single_done got=%0d exp=1", n_done); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== rep(16'h00C0) || got_layer[i] !== 32'd0 || got_row[i] !== 32'(i)) begin
        failures++;
        $display("FAIL single_row%0d got=%h/%0d/%0d exp=%h/0/%0d", i, got_data[i], got_layer[i], got_row[i], rep(16'h00C0), i);
      end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL single_error got=%b exp=0", bus.error); end
  endtask

  task automatic test_two_layers();
    logic [47:0] exp_d;
    capture_two_layers();
    drain(24, 1'b0, 1'b0);
    checks++; if (n_hs !== 6) begin failures++; $display("FAIL two_count got=%0d exp=6", n_hs); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL two_done got=%0d exp=1", n_done); end
    for (int i = 0; i < 6; i++) begin
      exp_d = (i < 3) ? rep(16'hFFC0) : rep(16'h00C0);
      checks++;
      if (got_data[i] !== exp_d || got_layer[i] !== 32'(i / 3) || got_row[i] !== 32'(i % 3)) begin
        failures++;
        $display("FAIL two_row%0d got=%h/%0d/%0d exp=%h/%0d/%0d", i, got_data[i], got_layer[i], got_row[i], exp_d, i / 3, i % 3);
      end
    end
  endtask

  task automatic test_saturation();
    logic [47:0] exp_d [3];
    exp_d[0] = rep(16'h1FFF);
    exp_d[1] = rep(16'hE000);
    exp_d[2] = {16'h00C0, 16'hE000, 16'h1FFF};
    send_slice(0, 0, 1'b1, 1'b1, rep(16'h7F00), rep(16'h0), rep(16'h7F00), rep(16'h7F00));
    send_slice(0, 1, 1'b1, 1'b0, rep(16'h8100), rep(16'h0), rep(16'h7F00), rep(16'h7F00));
    send_slice(0, 2, 1'b1, 1'b0, {16'h0200, 16'h8100, 16'h7F00}, rep(16'h0),
               {16'h0080, 16'h7F00, 16'h7F00}, {16'h0300, 16'h7F00, 16'h7F00});
    drain(20, 1'b0, 1'b0);
    checks++; if (n_hs !== 3) begin failures++; $display("FAIL sat_count got=%0d exp=3", n_hs); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL sat_row%0d got=%h exp=%h", i, got_data[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    capture_two_layers();
    drain(48, 1'b1, 1'b0);
    checks++; if (n_hs !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", n_hs); end
    checks++; if (hold_err !== 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", hold_err); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", n_done); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got_layer[i] !== 32'(i / 3) || got_row[i] !== 32'(i % 3)) begin
        failures++;
        $display("FAIL bp_order%0d got=%0d/%0d exp=%0d/%0d", i, got_layer[i], got_row[i], i / 3, i % 3);
      end
    end
  endtask

  task automatic test_index_error();
    capture_one_layer(16'h0200, 16'h0080, 16'h0300);
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL idx_pre got=%b exp=0", bus.error); end
    send_slice(4, 0, 1'b0, 1'b0, rep(16'h0), rep(16'h0100), rep(16'h0100), rep(16'h0100));
    checks++; if (bus.error !== 1'b1) begin failures++; $display("FAIL idx_layer got=%b exp=1", bus.error); end
    send_slice(0, 4, 1'b0, 1'b0, rep(16'h0), rep(16'h0100), rep(16'h0100), rep(16'h0100));
    drain(20, 1'b0, 1'b0);
    checks++; if (n_hs !== 3) begin failures++; $display("FAIL idx_count got=%0d exp=3", n_hs); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== rep(16'h00C0)) begin
        failures++;
        $display("FAIL idx_row%0d got=%h exp=%h", i, got_data[i], rep(16'h00C0));
      end
    end
    checks++; if (bus.error !== 1'b1) begin failures++; $display("FAIL idx_sticky got=%b exp=1", bus.error); end
  endtask

  task automatic test_reset_mid_drain();
    int  seen;
    bit  hit;
    seen = 0; hit = 0;
    capture_one_layer(16'h0200, 16'h0080, 16'h0300);
    bus.active_train     = 1'b1;
    bus.read_update_data = 1'b1;
    bus.update_ready     = 1'b1;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (bus.update_valid === 1'b1) begin
        seen++;
        if (seen == 2) begin
          reset = 1'b1;
          hit = 1;
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
    checks++; if (!hit) begin failures++; $display("FAIL rst_reach got=%0d exp=2", seen); end
    checks++; if (bus.update_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.update_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", bus.error); end
    idle_inputs();
    @(negedge clk);
    capture_one_layer(16'h7F00, 16'h7F00, 16'h7F00);
    drain(20, 1'b0, 1'b0);
    checks++; if (n_hs !== 3) begin failures++; $display("FAIL rst_count got=%0d exp=3", n_hs); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL rst_done got=%0d exp=1", n_done); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== rep(16'h1FFF) || got_row[i] !== 32'(i)) begin
        failures++;
        $display("FAIL rst_row%0d got=%h/%0d exp=%h/%0d", i, got_data[i], got_row[i], rep(16'h1FFF), i);
      end
    end
  endtask

  task automatic test_overrun();
    capture_one_layer(16'h0200, 16'h0080, 16'h0300);
    checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL ovr_pre got=%b exp=0", bus.error); end
    drain(20, 1'b0, 1'b1);
    checks++; if (bus.error !== 1'b1) begin failures++; $display("FAIL ovr_error got=%b exp=1", bus.error); end
    checks++; if (n_hs !== 3) begin failures++; $display("FAIL ovr_count got=%0d exp=3", n_hs); end
    checks++; if (n_done !== 1) begin failures++; $display("FAIL ovr_done got=%0d exp=1", n_done); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_data[i] !== rep(16'h00C0) || got_row[i] !== 32'(i)) begin
        failures++;
        $display("FAIL ovr_row%0d got=%h/%0d exp=%h/%0d", i, got_data[i], got_row[i], rep(16'h00C0), i);
      end
    end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ovr_idle got=%b exp=0", bus.busy); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.diff_dense  = '0;
    bus.diff_start  = '0;
    bus.diff_cost   = '0;
    bus.diff_to_all = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single_layer();
    test_two_layers();
    test_saturation();
    test_backpressure();
    test_index_error();
    test_reset_mid_drain();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
